// File: rtl/exe_muldiv_ctrl_if.sv
// EXE-stage to multiply/divide unit connection: issue, MTHI/MTLO, HI/LO read
// and the status/stall signals returned to the pipeline.
interface exe_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic             wr_hi;
    logic             wr_lo;
    logic             hilo_rd;
    logic             kill;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stall;

    modport master (
        output start, op, qa, qb, wr_hi, wr_lo, hilo_rd, kill,
        input  hi, lo, busy, done, div_zero, stall
    );

    modport slave (
        input  start, op, qa, qb, wr_hi, wr_lo, hilo_rd, kill,
        output hi, lo, busy, done, div_zero, stall
    );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO; works on
// magnitudes for WIDTH cycles, then fixes signs and writes back in one cycle.
module exe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    exe_muldiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, res;
    logic [CW-1:0]      cnt_q;
    logic               sgn_q, sa_q, sb_q, div_q, dz_q, done_q;

    logic               sgn_i, qb_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum, trial, diff;

    assign sgn_i   = ~bus.op[0];
    assign qb_zero = (bus.qb == '0);
    assign abs_a   = (sgn_i & bus.qa[WIDTH-1]) ? -bus.qa : bus.qa;
    assign abs_b   = (sgn_i & bus.qb[WIDTH-1]) ? -bus.qb : bus.qb;

    // acc holds {partial, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        acc_d = acc_q;
        sum   = '0;
        trial = '0;
        diff  = '0;
        if (!div_q) begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
            acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
            trial = acc_q[2*WIDTH-1:WIDTH-1];
            diff  = trial - {1'b0, b_q};
            acc_d = diff[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        res = acc_q;
        if (!div_q) begin
            if (sgn_q & (sa_q ^ sb_q)) res = -acc_q;
        end else begin
            res[WIDTH-1:0]       = (sgn_q & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            res[2*WIDTH-1:WIDTH] = (sgn_q & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.kill && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            // a kill in the same cycle drops the issue
                            if (!bus.kill) begin
                                sgn_q   <= sgn_i;
                                sa_q    <= bus.qa[WIDTH-1];
                                sb_q    <= bus.qb[WIDTH-1];
                                div_q   <= bus.op[1];
                                a_q     <= abs_a;
                                b_q     <= abs_b;
                                acc_q   <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
                                cnt_q   <= '0;
                                dz_q    <= bus.op[1] & qb_zero;
                                state_q <= (bus.op[1] & qb_zero) ? FIX : RUN;
                            end
                        end else begin
                            if (bus.wr_hi) hi_q <= bus.qa;
                            if (bus.wr_lo) lo_q <= bus.qa;
                        end
                    end
                    RUN: begin
                        acc_q <= acc_d;
                        if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
                        else                       cnt_q   <= cnt_q + 1'b1;
                    end
                    FIX: begin
                        if (!dz_q) begin
                            hi_q <= res[2*WIDTH-1:WIDTH];
                            lo_q <= res[WIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.stall    = bus.busy & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Scoreboard bench for exe_muldiv_ctrl: reference arithmetic on 64-bit ints,
// expected HI/LO pushed at issue and popped when done pulses.
module tb_exe_muldiv_ctrl;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exe_muldiv_ctrl_if #(.WIDTH(32)) bus ();

    exe_muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint la, lb, p, q, rm;
        logic   sg;
        sg = ~op[0];
        la = sg ? longint'($signed(a)) : longint'({32'b0, a});
        lb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        r  = '0;
        if (!op[1]) begin
            p    = la * lb;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'd0) begin
            r.hi = mhi;
            r.lo = mlo;
            r.dz = 1'b1;
        end else begin
            q    = la / lb;
            rm   = la % lb;
            r.lo = q[31:0];
            r.hi = rm[31:0];
        end
        return r;
    endfunction

    // Drives start for one cycle; returns in cycle 1 of the operation.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        sb.push_back(e);
        mhi = e.hi;
        mlo = e.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.qa    = a;
        bus.qb    = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        if (exp_lat > 2) chk("busy_c1", {63'b0, bus.busy}, 64'd1);
        while (!bus.done && lat < 60) begin
            tick();
            lat++;
            if (lat == exp_lat - 1) chk("busy_last", {63'b0, bus.busy}, 64'd1);
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_at_done", {63'b0, bus.busy}, 64'd0);
        chk("sb_size", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hi", {32'b0, bus.hi}, {32'b0, e.hi});
            chk("lo", {32'b0, bus.lo}, {32'b0, e.lo});
            chk("div_zero", {63'b0, bus.div_zero}, {63'b0, e.dz});
        end
    endtask

    initial begin
        int seen;
        bus.start = 0; bus.op = 0; bus.qa = 0; bus.qb = 0;
        bus.wr_hi = 0; bus.wr_lo = 0; bus.hilo_rd = 0; bus.kill = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_hi", {32'b0, bus.hi}, 64'd0);
        chk("rst_lo", {32'b0, bus.lo}, 64'd0);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_done", {63'b0, bus.done}, 64'd0);
        chk("rst_dz", {63'b0, bus.div_zero}, 64'd0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(34);
        chk("multu_hi_const", {32'b0, bus.hi}, 64'hFFFF_FFFE);
        chk("multu_lo_const", {32'b0, bus.lo}, 64'h0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);           wait_done(34);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);           wait_done(34);
        chk("div_q_const", {32'b0, bus.lo}, 64'hFFFF_FFFD);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done(34);
        chk("minint_q", {32'b0, bus.lo}, 64'h8000_0000);
        chk("minint_r", {32'b0, bus.hi}, 64'h0);

        bus.qa = 32'hCAFE; bus.wr_lo = 1'b1; tick(); bus.wr_lo = 1'b0;
        chk("mtlo", {32'b0, bus.lo}, 64'hCAFE);
        bus.qa = 32'h11; bus.wr_hi = 1'b1; tick(); bus.wr_hi = 1'b0;
        bus.qa = 32'h22; bus.wr_lo = 1'b1; tick(); bus.wr_lo = 1'b0;
        mhi = 32'h11; mlo = 32'h22;
        chk("mthi", {32'b0, bus.hi}, 64'h11);
        issue(2'b11, 32'd100, 32'd0);
        wait_done(2);

        // HI/LO read while busy stalls; an ALU op without it does not
        issue(2'b01, 32'd6, 32'd7);
        for (int c = 2; c <= 40; c++) begin
            tick();
            if (c == 5) chk("alu_nostall", {63'b0, bus.stall}, 64'd0);
            if (c >= 5) bus.hilo_rd = 1'b1;
            #1;
            if (c == 5 || c == 33) chk("rd_stall", {63'b0, bus.stall}, 64'd1);
            if (bus.done) begin
                chk("rd_done_cycle", 64'(c), 64'd34);
                chk("rd_stall_off", {63'b0, bus.stall}, 64'd0);
                chk("rd_lo", {32'b0, bus.lo}, 64'd42);
                void'(sb.pop_front());
                break;
            end
        end
        bus.hilo_rd = 1'b0;
        mhi = 32'd0; mlo = 32'd42;

        // MTHI while busy is held off until the first idle cycle
        issue(2'b01, 32'd2, 32'd3);
        tick(); tick();
        bus.wr_hi = 1'b1; bus.qa = 32'hBEEF; #1;
        chk("mthi_stall", {63'b0, bus.stall}, 64'd1);
        chk("mthi_held", {32'b0, bus.hi}, 64'd0);
        tick();
        sb[0].hi = 32'd0;
        sb[0].lo = 32'd6;
        begin
            int lat;
            lat = 4;
            while (!bus.done && lat < 60) begin tick(); lat++; end
            chk("mthi_busy_lat", 64'(lat), 64'd34);
            chk("mthi_pre_hi", {32'b0, bus.hi}, 64'd0);
            chk("mthi_pre_lo", {32'b0, bus.lo}, 64'd6);
            chk("mthi_idle_nostall", {63'b0, bus.stall}, 64'd0);
            void'(sb.pop_front());
        end
        tick(); bus.wr_hi = 1'b0;
        chk("mthi_after", {32'b0, bus.hi}, 64'hBEEF);
        mhi = 32'hBEEF; mlo = 32'd6;

        // kill mid-operation
        bus.start = 1'b1; bus.op = 2'b11; bus.qa = 32'd50; bus.qb = 32'd5;
        tick(); bus.start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        bus.kill = 1'b1; tick(); bus.kill = 1'b0;
        chk("kill_busy", {63'b0, bus.busy}, 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin seen |= int'(bus.done); tick(); end
        chk("kill_no_done", 64'(seen), 64'd0);
        chk("kill_hi", {32'b0, bus.hi}, {32'b0, mhi});
        chk("kill_lo", {32'b0, bus.lo}, {32'b0, mlo});

        // reset mid-operation
        bus.start = 1'b1; bus.op = 2'b11; bus.qa = 32'd50; bus.qb = 32'd5;
        tick(); bus.start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        mhi = '0; mlo = '0;
        chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_mid_hi", {32'b0, bus.hi}, 64'd0);
        chk("rst_mid_lo", {32'b0, bus.lo}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            issue(rop, ra, rb);
            wait_done((rop[1] && rb == 32'd0) ? 2 : 34);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
